// File: rtl/axis_pkg.sv
// Shared types and default widths for the AXI-Stream packet source.
package axis_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int LEN_WIDTH_DEF  = 16;
  localparam int GAP_WIDTH_DEF  = 8;
  localparam int PKT_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  // Field widths follow the package defaults; the top uses the same defaults.
  typedef struct packed {
    logic [LEN_WIDTH_DEF-1:0]  len;
    logic [DATA_WIDTH_DEF-1:0] seed;
    logic [GAP_WIDTH_DEF-1:0]  gap;
  } cmd_t;

endpackage

// File: rtl/axis_packet_source.sv
// AXI-Stream packet generator: one command yields an incrementing-data packet,
// m_last on the final beat, then an optional idle gap before the next command.
module axis_packet_source
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int GAP_WIDTH  = GAP_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [LEN_WIDTH-1:0]     cmd_len,
  input  logic [DATA_WIDTH-1:0]    cmd_seed,
  input  logic [GAP_WIDTH-1:0]     cmd_gap,
  output logic                     m_valid,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_last,
  input  logic                     m_ready,
  output logic                     busy,
  output logic [PKT_CNT_WIDTH-1:0] pkt_count
);

  state_t                   state_q, state_d;
  logic [LEN_WIDTH-1:0]     len_q, len_d;
  logic [GAP_WIDTH-1:0]     gap_q, gap_d;
  logic [LEN_WIDTH-1:0]     beat_cnt_q, beat_cnt_d;
  logic [GAP_WIDTH-1:0]     gap_cnt_q, gap_cnt_d;
  logic                     m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]    m_data_q, m_data_d;
  logic                     m_last_q, m_last_d;
  logic [PKT_CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;

  cmd_t                     cmd_in;
  logic                     xfer;
  logic [LEN_WIDTH-1:0]     beat_nxt;

  assign cmd_in    = '{len: cmd_len, seed: cmd_seed, gap: cmd_gap};
  assign xfer      = m_valid_q && m_ready;
  assign beat_nxt  = beat_cnt_q + LEN_WIDTH'(1);

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign pkt_count = pkt_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      gap_q       <= '0;
      beat_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      beat_cnt_q  <= beat_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    gap_d       = gap_q;
    beat_cnt_d  = beat_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    pkt_count_d = pkt_count_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          len_d      = cmd_in.len;
          gap_d      = cmd_in.gap;
          m_data_d   = cmd_in.seed;
          m_valid_d  = 1'b1;
          m_last_d   = (cmd_in.len == '0);
          beat_cnt_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        // Outputs only move on an accepted beat, so a stall holds them exactly.
        if (xfer) begin
          if (m_last_q) begin
            m_valid_d   = 1'b0;
            m_last_d    = 1'b0;
            pkt_count_d = pkt_count_q + PKT_CNT_WIDTH'(1);
            if (gap_q != '0) begin
              gap_cnt_d = gap_q;
              state_d   = GAP;
            end else begin
              state_d   = IDLE;
            end
          end else begin
            m_data_d   = m_data_q + DATA_WIDTH'(1);
            beat_cnt_d = beat_nxt;
            m_last_d   = (beat_nxt == len_q);
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_WIDTH'(1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
